// File: rtl/dmem_access_ctrl_if.sv
// Requester-side bus for the data-memory access controller: one instance per requester.
// The requester drives the access fields; the controller returns grant and response.
interface dmem_access_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    wsel;
    logic [2:0]    rsel;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, addr, wdata, wsel, rsel,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, wsel, rsel,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Shares one DMEM port between CPU and DMA requesters, tracks the one-cycle read
// latency, and turns accesses the memory cannot perform into error responses.
module dmem_access_ctrl #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MEM_ADDR_BITS = 20,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_access_ctrl_if.slave cpu,
    dmem_access_ctrl_if.slave dma,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_dataw,
    output logic              mem_memrw,
    output logic [1:0]        mem_wsel,
    output logic [2:0]        mem_rsel,
    input  logic [DW-1:0]     mem_datar,
    output logic              busy
);

    typedef enum logic {IDLE, RESP} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;
    typedef enum logic {KIND_DATA, KIND_ERR} kind_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    kind_e         kind_q, kind_d;
    logic [3:0]    starve_q, starve_d;

    logic          cpu_win;
    logic          dma_win;
    logic          grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [1:0]    sel_wsel;
    logic [2:0]    sel_rsel;
    logic          sel_legal;
    logic          cpu_resp;
    logic          dma_resp;

    // Word-aligned, inside the decoded window, and a size code the memory knows.
    function automatic logic is_legal(input logic          we,
                                      input logic [AW-1:0] addr,
                                      input logic [1:0]    wsel,
                                      input logic [2:0]    rsel);
        logic ok;
        ok = (addr[1:0] == 2'b00) && (addr[AW-1:MEM_ADDR_BITS] == '0);
        if (we) begin
            ok = ok && (wsel != 2'b11);
        end else begin
            ok = ok && (rsel inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b101});
        end
        return ok;
    endfunction

    always_comb begin
        dma_win = rst_n && dma.req && (!cpu.req || (starve_q == LIMIT));
        cpu_win = rst_n && cpu.req && !dma_win;
        grant   = cpu_win || dma_win;
        if (dma_win) begin
            sel_we    = dma.we;
            sel_addr  = dma.addr;
            sel_wdata = dma.wdata;
            sel_wsel  = dma.wsel;
            sel_rsel  = dma.rsel;
        end else begin
            sel_we    = cpu.we;
            sel_addr  = cpu.addr;
            sel_wdata = cpu.wdata;
            sel_wsel  = cpu.wsel;
            sel_rsel  = cpu.rsel;
        end
        sel_legal = is_legal(sel_we, sel_addr, sel_wsel, sel_rsel);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            kind_q   <= KIND_DATA;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            kind_q   <= kind_d;
            starve_q <= starve_d;
        end
    end

    // Only loads and rejected accesses owe a response; legal stores finish silently.
    always_comb begin
        state_d = IDLE;
        owner_d = OWN_NONE;
        kind_d  = KIND_DATA;
        if (grant && (!sel_we || !sel_legal)) begin
            state_d = RESP;
            owner_d = dma_win ? OWN_DMA : OWN_CPU;
            kind_d  = sel_legal ? KIND_DATA : KIND_ERR;
        end

        if (!dma.req || dma_win) begin
            starve_d = '0;
        end else if (starve_q == LIMIT) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Anything not a legal grant parks the memory on a harmless word read of address 0.
    always_comb begin
        mem_addr  = '0;
        mem_dataw = '0;
        mem_memrw = 1'b0;
        mem_wsel  = 2'b10;
        mem_rsel  = 3'b011;
        if (grant && sel_legal) begin
            mem_addr  = sel_addr;
            mem_dataw = sel_wdata;
            mem_memrw = sel_we;
            mem_wsel  = sel_wsel;
            mem_rsel  = sel_rsel;
        end

        cpu.gnt = cpu_win;
        dma.gnt = dma_win;
        busy    = (state_q == RESP);

        cpu_resp   = (state_q == RESP) && (owner_q == OWN_CPU);
        dma_resp   = (state_q == RESP) && (owner_q == OWN_DMA);
        cpu.rvalid = cpu_resp && (kind_q == KIND_DATA);
        cpu.err    = cpu_resp && (kind_q == KIND_ERR);
        dma.rvalid = dma_resp && (kind_q == KIND_DATA);
        dma.err    = dma_resp && (kind_q == KIND_ERR);
        cpu.rdata  = cpu.rvalid ? mem_datar : '0;
        dma.rdata  = dma.rvalid ? mem_datar : '0;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural registered-read DMEM model.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_init;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataw;
    logic        mem_memrw;
    logic [1:0]  mem_wsel;
    logic [2:0]  mem_rsel;
    logic [31:0] mem_datar;
    logic        busy;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.AW(32), .DW(32)) cpu_if ();
    dmem_access_ctrl_if #(.AW(32), .DW(32)) dma_if ();

    dmem_access_ctrl #(
        .AW(32), .DW(32), .MEM_ADDR_BITS(20), .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (cpu_if),
        .dma       (dma_if),
        .mem_addr  (mem_addr),
        .mem_dataw (mem_dataw),
        .mem_memrw (mem_memrw),
        .mem_wsel  (mem_wsel),
        .mem_rsel  (mem_rsel),
        .mem_datar (mem_datar),
        .busy      (busy)
    );

    // DMEM model: little-endian words, registered read with RSel extension.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        logic [31:0] w;
        w = mem[mem_addr[9:2]];
        case (mem_rsel)
            3'b000:  mem_datar <= {{24{w[7]}}, w[7:0]};
            3'b010:  mem_datar <= {{16{w[15]}}, w[15:0]};
            3'b011:  mem_datar <= w;
            3'b100:  mem_datar <= {24'b0, w[7:0]};
            3'b101:  mem_datar <= {16'b0, w[15:0]};
            default: mem_datar <= 32'h0;
        endcase
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | (i << 2);
        end else if (mem_memrw) begin
            case (mem_wsel)
                2'b00:   mem[mem_addr[9:2]][7:0]  <= mem_dataw[7:0];
                2'b01:   mem[mem_addr[9:2]][15:0] <= mem_dataw[15:0];
                default: mem[mem_addr[9:2]]       <= mem_dataw;
            endcase
        end
    end

    typedef struct {
        string       name;
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wdata;
        logic [1:0]  c_wsel;
        logic [2:0]  c_rsel;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic [1:0]  d_wsel;
        logic [2:0]  d_rsel;
        logic        e_cgnt, e_dgnt, e_memrw, e_busy;
        logic        e_crv, e_cerr, e_drv, e_derr;
        logic [31:0] e_crdata, e_drdata;
    } vec_t;

    function automatic vec_t nop(input string name);
        vec_t v;
        v.name = name;
        v.c_req = 0; v.c_we = 0; v.c_addr = 0; v.c_wdata = 0; v.c_wsel = 2'b10; v.c_rsel = 3'b011;
        v.d_req = 0; v.d_we = 0; v.d_addr = 0; v.d_wdata = 0; v.d_wsel = 2'b10; v.d_rsel = 3'b011;
        v.e_cgnt = 0; v.e_dgnt = 0; v.e_memrw = 0; v.e_busy = 0;
        v.e_crv = 0; v.e_cerr = 0; v.e_drv = 0; v.e_derr = 0;
        v.e_crdata = 0; v.e_drdata = 0;
        return v;
    endfunction

    function automatic vec_t cpu_acc(input vec_t v, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [1:0] wsel,
                                     input logic [2:0] rsel);
        v.c_req = 1; v.c_we = we; v.c_addr = addr; v.c_wdata = wdata; v.c_wsel = wsel; v.c_rsel = rsel;
        return v;
    endfunction

    function automatic vec_t dma_acc(input vec_t v, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [1:0] wsel,
                                     input logic [2:0] rsel);
        v.d_req = 1; v.d_we = we; v.d_addr = addr; v.d_wdata = wdata; v.d_wsel = wsel; v.d_rsel = rsel;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t v, input logic cgnt, input logic dgnt,
                                input logic memrw, input logic bsy);
        v.e_cgnt = cgnt; v.e_dgnt = dgnt; v.e_memrw = memrw; v.e_busy = bsy;
        return v;
    endfunction

    function automatic vec_t rc(input vec_t v, input logic rv, input logic [31:0] rdata, input logic err);
        v.e_crv = rv; v.e_crdata = rdata; v.e_cerr = err;
        return v;
    endfunction

    function automatic vec_t rd(input vec_t v, input logic rv, input logic [31:0] rdata, input logic err);
        v.e_drv = rv; v.e_drdata = rdata; v.e_derr = err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cpu_if.req = v.c_req; cpu_if.we = v.c_we; cpu_if.addr = v.c_addr;
        cpu_if.wdata = v.c_wdata; cpu_if.wsel = v.c_wsel; cpu_if.rsel = v.c_rsel;
        dma_if.req = v.d_req; dma_if.we = v.d_we; dma_if.addr = v.d_addr;
        dma_if.wdata = v.d_wdata; dma_if.wsel = v.d_wsel; dma_if.rsel = v.d_rsel;
    endtask

    task automatic check_vec(input vec_t v);
        checkOutput({v.name, ".cpu_gnt"},    cpu_if.gnt,    v.e_cgnt);
        checkOutput({v.name, ".dma_gnt"},    dma_if.gnt,    v.e_dgnt);
        checkOutput({v.name, ".memrw"},      mem_memrw,     v.e_memrw);
        checkOutput({v.name, ".busy"},       busy,          v.e_busy);
        checkOutput({v.name, ".cpu_rvalid"}, cpu_if.rvalid, v.e_crv);
        checkOutput({v.name, ".cpu_rdata"},  cpu_if.rdata,  v.e_crdata);
        checkOutput({v.name, ".cpu_err"},    cpu_if.err,    v.e_cerr);
        checkOutput({v.name, ".dma_rvalid"}, dma_if.rvalid, v.e_drv);
        checkOutput({v.name, ".dma_rdata"},  dma_if.rdata,  v.e_drdata);
        checkOutput({v.name, ".dma_err"},    dma_if.err,    v.e_derr);
    endtask

    function automatic logic [31:0] flags();
        return {24'b0, cpu_if.gnt, dma_if.gnt, cpu_if.rvalid, dma_if.rvalid,
                cpu_if.err, dma_if.err, mem_memrw, busy};
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tv[$];
        vec_t v;
        int   prev;
        logic exp_d;

        tv.push_back(ex(cpu_acc(nop("sw100"), 1, 32'h100, 32'hDEADBEEF, 2'b10, 3'b011), 1, 0, 1, 0));
        tv.push_back(ex(cpu_acc(nop("lb100"), 0, 32'h100, 32'h0, 2'b10, 3'b000), 1, 0, 0, 0));
        tv.push_back(rc(ex(cpu_acc(nop("lhu100"), 0, 32'h100, 32'h0, 2'b10, 3'b101), 1, 0, 0, 1), 1, 32'hFFFFFFEF, 0));
        tv.push_back(rc(ex(nop("lhu_rsp"), 0, 0, 0, 1), 1, 32'h0000BEEF, 0));
        tv.push_back(nop("idle1"));
        tv.push_back(ex(dma_acc(nop("dma_mis"), 1, 32'h102, 32'h12345678, 2'b10, 3'b011), 0, 1, 0, 0));
        tv.push_back(rd(ex(cpu_acc(nop("cpu_oor"), 0, 32'h0010_0000, 32'h0, 2'b10, 3'b011), 1, 0, 0, 1), 0, 0, 1));
        tv.push_back(rc(ex(cpu_acc(nop("cpu_rsel"), 0, 32'h100, 32'h0, 2'b10, 3'b001), 1, 0, 0, 1), 0, 0, 1));
        tv.push_back(rc(ex(nop("err_rsel"), 0, 0, 0, 1), 0, 0, 1));
        tv.push_back(ex(cpu_acc(nop("lw100"), 0, 32'h100, 32'h0, 2'b10, 3'b011), 1, 0, 0, 0));
        tv.push_back(rc(ex(nop("lw100_rsp"), 0, 0, 0, 1), 1, 32'hDEADBEEF, 0));
        tv.push_back(ex(cpu_acc(nop("sw_ws3"), 1, 32'h104, 32'h0, 2'b11, 3'b011), 1, 0, 0, 0));
        tv.push_back(rc(ex(nop("err_ws3"), 0, 0, 0, 1), 0, 0, 1));
        tv.push_back(ex(cpu_acc(nop("lw104"), 0, 32'h104, 32'h0, 2'b10, 3'b011), 1, 0, 0, 0));
        tv.push_back(rc(ex(nop("lw104_rsp"), 0, 0, 0, 1), 1, 32'hA500_0104, 0));
        tv.push_back(ex(cpu_acc(nop("lw0"), 0, 32'h0, 32'h0, 2'b10, 3'b011), 1, 0, 0, 0));
        tv.push_back(rc(ex(cpu_acc(nop("lw4"), 0, 32'h4, 32'h0, 2'b10, 3'b011), 1, 0, 0, 1), 1, 32'hA500_0000, 0));
        tv.push_back(rc(ex(cpu_acc(nop("lw8"), 0, 32'h8, 32'h0, 2'b10, 3'b011), 1, 0, 0, 1), 1, 32'hA500_0004, 0));
        tv.push_back(rc(ex(nop("b2b_rsp"), 0, 0, 0, 1), 1, 32'hA500_0008, 0));
        tv.push_back(nop("idle2"));
        tv.push_back(ex(dma_acc(nop("dma_sw40"), 1, 32'h40, 32'hCAFEF00D, 2'b10, 3'b011), 0, 1, 1, 0));
        tv.push_back(ex(dma_acc(nop("dma_lw40"), 0, 32'h40, 32'h0, 2'b10, 3'b011), 0, 1, 0, 0));
        tv.push_back(rd(ex(nop("dma_rsp"), 0, 0, 0, 1), 1, 32'hCAFEF00D, 0));
        tv.push_back(ex(cpu_acc(nop("cpu_sb40"), 1, 32'h40, 32'h0000_0011, 2'b00, 3'b011), 1, 0, 1, 0));
        tv.push_back(ex(cpu_acc(nop("cpu_lw40"), 0, 32'h40, 32'h0, 2'b10, 3'b011), 1, 0, 0, 0));
        tv.push_back(rc(ex(nop("sb_rsp"), 0, 0, 0, 1), 1, 32'hCAFEF011, 0));
        tv.push_back(nop("idle3"));

        // Reset with a store request pending: nothing may be granted or written.
        rst_n    = 1'b0;
        mem_init = 1'b1;
        applyStimulus(cpu_acc(nop("rst"), 1, 32'h0, 32'hBAD0BAD0, 2'b10, 3'b011));
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst.flags", flags(), 32'h0);
        checkOutput("rst.cpu_rdata", cpu_if.rdata, 32'h0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(nop("idle"));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("idle%0d.flags", k), flags(), 32'h0);
            @(posedge clk); #1;
        end

        foreach (tv[i]) begin
            applyStimulus(tv[i]);
            @(negedge clk);
            check_vec(tv[i]);
            @(posedge clk); #1;
        end

        // Contention: DMA forced through every fifth cycle; dropping dma_req clears the count.
        prev = 0;
        for (int k = 1; k <= 18; k++) begin
            v = cpu_acc(nop("cont"), 0, 32'h10, 32'h0, 2'b10, 3'b011);
            if (k != 13) v = dma_acc(v, 0, 32'h20, 32'h0, 2'b10, 3'b011);
            applyStimulus(v);
            @(negedge clk);
            exp_d = (k == 5) || (k == 10) || (k == 18);
            checkOutput($sformatf("cont%0d.dma_gnt", k), dma_if.gnt, exp_d);
            checkOutput($sformatf("cont%0d.cpu_gnt", k), cpu_if.gnt, !exp_d);
            checkOutput($sformatf("cont%0d.cpu_rdata", k), cpu_if.rdata, (prev == 1) ? 32'hA500_0010 : 32'h0);
            checkOutput($sformatf("cont%0d.dma_rdata", k), dma_if.rdata, (prev == 2) ? 32'hA500_0020 : 32'h0);
            checkOutput($sformatf("cont%0d.rvalid", k), {cpu_if.rvalid, dma_if.rvalid},
                        {(prev == 1), (prev == 2)});
            prev = exp_d ? 2 : 1;
            @(posedge clk); #1;
        end
        applyStimulus(nop("cont_end"));
        @(negedge clk);
        checkOutput("cont_end.dma_rvalid", dma_if.rvalid, 1'b1);
        checkOutput("cont_end.dma_rdata", dma_if.rdata, 32'hA500_0020);
        @(posedge clk); #1;

        // Reset mid-operation: CPU LW granted, reset at the next edge, counter at 3 beforehand.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(dma_acc(cpu_acc(nop("pre"), 0, 32'h0, 32'h0, 2'b10, 3'b011),
                                  0, 32'h20, 32'h0, 2'b10, 3'b011));
            @(negedge clk);
            checkOutput($sformatf("pre%0d.cpu_gnt", k), cpu_if.gnt, 1'b1);
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            applyStimulus(dma_acc(cpu_acc(nop("inrst"), 1, 32'h0, 32'hBAD0BAD0, 2'b10, 3'b011),
                                  0, 32'h20, 32'h0, 2'b10, 3'b011));
            @(negedge clk);
            checkOutput($sformatf("inrst%0d.flags", k), flags(), 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(dma_acc(cpu_acc(nop("post"), 0, 32'h0, 32'h0, 2'b10, 3'b011),
                                  0, 32'h20, 32'h0, 2'b10, 3'b011));
            @(negedge clk);
            checkOutput($sformatf("post%0d.dma_gnt", k), dma_if.gnt, k == 5);
            if (k == 1) checkOutput("post1.busy", busy, 1'b0);
            if (k == 2) checkOutput("post2.cpu_rdata", cpu_if.rdata, 32'hA500_0000);
            @(posedge clk); #1;
        end
        applyStimulus(nop("done"));
        @(negedge clk);
        checkOutput("done.dma_rdata", dma_if.rdata, 32'hA500_0020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
